// File: rtl/alu_result_queue.sv
// alu_result_queue: buffers ALU results with their destination tag, NZP flags
// and a divide-by-zero marker in a small circular FIFO that drains to
// register-file writeback over a valid/ready handshake.
module alu_result_queue #(
  parameter int DATA_BITS = 8,
  parameter int TAG_BITS  = 4,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [DATA_BITS-1:0]     in_rt,
  input  logic [DATA_BITS-1:0]     in_result,
  input  logic [TAG_BITS-1:0]      in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITS-1:0]     out_result,
  output logic [TAG_BITS-1:0]      out_rd,
  output logic [2:0]               out_nzp,
  output logic                     out_dz,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               dz_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [DATA_BITS-1:0] mem_result [DEPTH];
  logic [TAG_BITS-1:0]  mem_rd     [DEPTH];
  logic [2:0]           mem_nzp    [DEPTH];
  logic                 mem_dz     [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic                 push;
  logic                 pop;
  logic                 in_dz;
  logic [DATA_BITS-1:0] in_value;
  logic [2:0]           in_nzp;

  // Handshake and flag derivation for the incoming result.
  always_comb begin
    in_ready  = (count != CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    in_dz     = (in_op == OP_DIV) && (in_rt == '0);
    in_value  = in_dz ? {DATA_BITS{1'b1}} : in_result;
    in_nzp[1] = (in_value == '0);
    in_nzp[2] = in_value[DATA_BITS-1];
    in_nzp[0] = ~in_nzp[2] & ~in_nzp[1];
  end

  // Show-ahead head entry; values are meaningless while out_valid is low.
  always_comb begin
    out_result = mem_result[rd_ptr];
    out_rd     = mem_rd[rd_ptr];
    out_nzp    = mem_nzp[rd_ptr];
    out_dz     = mem_dz[rd_ptr];
  end

  // Storage is written on push only and deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_value;
      mem_rd[wr_ptr]     <= in_rd;
      mem_nzp[wr_ptr]    <= in_nzp;
      mem_dz[wr_ptr]     <= in_dz;
    end
  end

  // Pointers, occupancy and the saturating divide-by-zero counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dz_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push && in_dz && (dz_count != 8'hFF)) dz_count <= dz_count + 8'd1;
    end
  end

endmodule
